// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer and channel scheduler for the
// convolutional encoder -> channel -> Viterbi decoder chain.
// Feeds payload plus zero tail bits to the encoder, keeps a latency-matched
// reference of the payload to score decoded bits, and schedules channel
// error bursts.
// Build option: define VITERBI_ERR_INJ_EN to include the error scheduler;
// without it err_mask_o and inj_ct_o are tied to zero.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN  = 64,
    parameter int TAIL_LEN   = 2,
    parameter int DEC_LAT    = 16,
    parameter int ERR_N      = 4,
    parameter int ERR_WINDOW = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic        src_data_i,
    output logic        src_ready_o,
    output logic        enc_enable_o,
    output logic        enc_data_o,
    input  logic        enc_valid_i,
    output logic        dec_enable_o,
    output logic [1:0]  err_mask_o,
    input  logic        dec_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);
    localparam int PAY_W  = $clog2(FRAME_LEN + 1);
    localparam int TAIL_W = $clog2(TAIL_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [PAY_W-1:0]   pay_ct;
    logic [TAIL_W-1:0]  tail_ct;
    logic               frame_start;
    logic               handshake;
    logic               enc_en_nxt;
    logic               enc_dat_nxt;
    logic               enc_pay;
    logic [DEC_LAT-1:0] ref_vld_p;
    logic [DEC_LAT-1:0] ref_pay_p;
    logic [DEC_LAT-1:0] ref_bit_p;
    logic               ref_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign frame_start = (state == S_IDLE) && start_i;
    assign handshake   = (state == S_PAYLOAD) && src_valid_i;
    assign ref_err     = ref_vld_p[DEC_LAT-1] && ref_pay_p[DEC_LAT-1] &&
                         (ref_bit_p[DEC_LAT-1] != dec_data_i);

    // Next-state decode and next encoder drive for the frame sequencer
    always_comb begin
        state_nxt   = state;
        src_ready_o = 1'b0;
        busy_o      = (state != S_IDLE);
        done_o      = 1'b0;
        enc_en_nxt  = 1'b0;
        enc_dat_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                src_ready_o = 1'b1;
                if (src_valid_i) begin
                    enc_en_nxt  = 1'b1;
                    enc_dat_nxt = src_data_i;
                    if (pay_ct == PAY_W'(FRAME_LEN - 1)) state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                enc_en_nxt = 1'b1;
                if (tail_ct == TAIL_W'(TAIL_LEN - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // the last tail entry may still be on enc_enable_o, not yet in the pipe
                if ((ref_vld_p == '0) && !enc_enable_o) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus payload and tail counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pay_ct  <= '0;
            tail_ct <= '0;
        end else begin
            state <= state_nxt;
            if (frame_start)    pay_ct <= '0;
            else if (handshake) pay_ct <= pay_ct + 1'b1;
            if (state == S_TAIL) tail_ct <= tail_ct + 1'b1;
            else                 tail_ct <= '0;
        end
    end

    // Encoder drive stage and decoder enable (encoder valid delayed one cycle)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_enable_o <= 1'b0;
            enc_data_o   <= 1'b0;
            enc_pay      <= 1'b0;
            dec_enable_o <= 1'b0;
        end else begin
            enc_enable_o <= enc_en_nxt;
            enc_data_o   <= enc_dat_nxt;
            enc_pay      <= handshake;
            dec_enable_o <= enc_valid_i;
        end
    end

    // Reference pipe: DEC_LAT stages of {valid, payload flag, bit}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_vld_p <= '0;
            ref_pay_p <= '0;
            ref_bit_p <= '0;
        end else begin
            ref_vld_p <= (ref_vld_p << 1) | DEC_LAT'(enc_enable_o);
            ref_pay_p <= (ref_pay_p << 1) | DEC_LAT'(enc_pay);
            ref_bit_p <= (ref_bit_p << 1) | DEC_LAT'(enc_data_o);
        end
    end

    // Bit-error counter: payload entries only, saturating, cleared on frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             bit_err_ct_o <= '0;
        else if (frame_start) bit_err_ct_o <= '0;
        else if (ref_err)     bit_err_ct_o <= sat_inc(bit_err_ct_o);
    end

`ifdef VITERBI_ERR_INJ_EN
    localparam logic [15:0] ERR_BITS = 16'((1 << ERR_N) - 1);

    logic [15:0] wc;
    logic [1:0]  mask_nxt;

    // Burst decision for the symbol currently strobed by enc_valid_i
    always_comb begin
        mask_nxt = 2'b00;
        if (enc_valid_i && ({1'b0, wc} < 17'(ERR_WINDOW)) &&
            ((wc & ERR_BITS) >= (ERR_BITS - 16'd1)))
            mask_nxt = 2'b10;
    end

    // Channel mask register, word counter and injection counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc         <= '0;
            err_mask_o <= 2'b00;
            inj_ct_o   <= '0;
        end else begin
            err_mask_o <= mask_nxt;
            if (frame_start) begin
                wc       <= '0;
                inj_ct_o <= '0;
            end else begin
                if (enc_valid_i)         wc       <= sat_inc(wc);
                if (mask_nxt != 2'b00)   inj_ct_o <= sat_inc(inj_ct_o);
            end
        end
    end
`else
    assign err_mask_o = 2'b00;
    assign inj_ct_o   = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: random payloads and source
// valid patterns, an ideal decoder with programmable bit flips, and a
// scoreboard comparing encoder stream, channel mask and per-frame counters.
module tb_viterbi_frame_ctrl;
    localparam int FRAME_LEN  = 64;
    localparam int TAIL_LEN   = 2;
    localparam int DEC_LAT    = 16;
    localparam int ERR_N      = 4;
    localparam int ERR_WINDOW = 256;
    localparam int SYMS       = FRAME_LEN + TAIL_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        src_valid_i = 1'b0;
    logic        src_data_i = 1'b0;
    logic        dec_data_i = 1'b0;
    logic        enc_valid_i;
    logic        src_ready_o, enc_enable_o, enc_data_o, dec_enable_o, busy_o, done_o;
    logic [1:0]  err_mask_o;
    logic [15:0] bit_err_ct_o, inj_ct_o;

    int n_checks = 0;
    int n_fail   = 0;

    // encoder model: output valid in the same cycle as its enable
    assign enc_valid_i = enc_enable_o;

    viterbi_frame_ctrl #(
        .FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT),
        .ERR_N(ERR_N), .ERR_WINDOW(ERR_WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .enc_enable_o(enc_enable_o), .enc_data_o(enc_data_o), .enc_valid_i(enc_valid_i),
        .dec_enable_o(dec_enable_o), .err_mask_o(err_mask_o), .dec_data_i(dec_data_i),
        .busy_o(busy_o), .done_o(done_o),
        .bit_err_ct_o(bit_err_ct_o), .inj_ct_o(inj_ct_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference rule: symbol wc gets a burst if inside the window and in the
    // last two positions of each 2**ERR_N period.
    function automatic bit inj_rule(input int wc);
`ifdef VITERBI_ERR_INJ_EN
        int per;
        per = 1 << ERR_N;
        return (wc < ERR_WINDOW) && ((wc % per) >= (per - 2));
`else
        return (wc < 0);
`endif
    endfunction

    // scoreboard state
    bit exp_bits[$];
    int exp_err_q[$], exp_inj_q[$], exp_en_q[$], exp_run_q[$];
    bit flip[SYMS];
    bit hist[$];
    bit in_frame = 1'b0;
    bit hs_prev  = 1'b0;
    bit en_prev  = 1'b0;
    int env_n = 0, pay_seen = 0, en_ct = 0, run = 0, last_run = 0, wc_m = 0;
    int frames_done = 0;

    task automatic set_flips(input int a, input int b, input int c);
        for (int i = 0; i < SYMS; i++) flip[i] = 1'b0;
        if (a >= 0) flip[a] = 1'b1;
        if (b >= 0) flip[b] = 1'b1;
        if (c >= 0) flip[c] = 1'b1;
    endtask

    // Monitor + ideal decoder model, sampled mid-cycle
    always @(negedge clk) begin
        bit cur;
        cur = enc_data_o ^ (enc_enable_o && (env_n < SYMS) && flip[env_n]);
        hist.push_back(cur);
        if (hist.size() > DEC_LAT) dec_data_i = hist.pop_front();
        if (rst) begin
            if (!in_frame) check("enable_outside_frame", enc_enable_o, 0);
            if (in_frame && pay_seen < FRAME_LEN)
                check("enable_follows_handshake", enc_enable_o, hs_prev);
            if (enc_enable_o && in_frame) begin
                if (exp_bits.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL enc_data_queue: got an enable, expected none");
                end else begin
                    check("enc_data", enc_data_o, exp_bits.pop_front());
                end
                env_n++;
                en_ct++;
                run++;
                if (pay_seen < FRAME_LEN) pay_seen++;
            end else if (!enc_enable_o && run > 0) begin
                last_run = run;
                run = 0;
            end
            check("dec_enable_delay", dec_enable_o, en_prev);
            if (dec_enable_o) begin
                check("err_mask", err_mask_o, inj_rule(wc_m) ? 2 : 0);
                wc_m++;
            end else begin
                check("err_mask_idle", err_mask_o, 0);
            end
            if (done_o) begin
                frames_done++;
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, expected 0");
                end else begin
                    int er;
                    check("bit_err_ct", bit_err_ct_o, exp_err_q.pop_front());
                    check("inj_ct", inj_ct_o, exp_inj_q.pop_front());
                    check("enable_count", en_ct, exp_en_q.pop_front());
                    er = exp_run_q.pop_front();
                    if (er >= 0) check("final_enable_run", last_run, er);
                    check("busy_at_done", busy_o, 1);
                    check("leftover_bits", exp_bits.size(), 0);
                end
                in_frame = 1'b0;
            end
        end
        hs_prev = src_valid_i & src_ready_o;
        en_prev = rst ? enc_valid_i : 1'b0;
    end

    // vmode: 0 always valid, 1 toggling, 2 random. abort_at>0 returns after that many bits.
    task automatic run_frame(input int vmode, input bit a5, input int abort_at, input bit poke);
        bit         pay[FRAME_LEN];
        logic [7:0] a5b;
        int         idx, budget, exp_err, exp_inj, base;
        a5b = 8'hA5;
        idx = 0; budget = 0; exp_err = 0; exp_inj = 0;
        for (int i = 0; i < FRAME_LEN; i++)
            pay[i] = a5 ? a5b[7 - (i % 8)] : 1'($urandom_range(0, 1));
        for (int i = 0; i < FRAME_LEN; i++) exp_err += int'(flip[i]);
        for (int w = 0; w < SYMS; w++) exp_inj += int'(inj_rule(w));
        exp_err_q.push_back(exp_err);
        exp_inj_q.push_back(exp_inj);
        exp_en_q.push_back(SYMS);
        exp_run_q.push_back(vmode == 0 ? SYMS : (vmode == 1 ? TAIL_LEN + 1 : -1));
        env_n = 0; pay_seen = 0; en_ct = 0; run = 0; last_run = 0; wc_m = 0;
        in_frame = 1'b1;
        base = frames_done;
        start_i = 1'b1;
        while (idx < FRAME_LEN && budget < 1000) begin
            src_valid_i = (vmode == 0) ? 1'b1 :
                          (vmode == 1) ? ((budget % 2) == 0) : 1'($urandom_range(0, 1));
            src_data_i = pay[idx];
            @(negedge clk);
            if (src_valid_i && src_ready_o) begin
                exp_bits.push_back(pay[idx]);
                idx++;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            budget++;
            if (abort_at > 0 && idx == abort_at) begin
                src_valid_i = 1'b0;
                return;
            end
        end
        src_valid_i = 1'b0;
        if (idx < FRAME_LEN) begin
            n_checks++;
            n_fail++;
            $display("FAIL payload_accept_timeout: got %0d bits, expected %0d", idx, FRAME_LEN);
        end
        for (int i = 0; i < TAIL_LEN; i++) exp_bits.push_back(1'b0);
        if (poke) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        budget = 0;
        while (frames_done == base && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        check("done_seen", frames_done, base + 1);
    endtask

    initial begin
        int base;
        set_flips(-1, -1, -1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_ready", src_ready_o, 0);
        check("reset_enc_enable", enc_enable_o, 0);
        check("reset_err_mask", err_mask_o, 0);
        check("reset_bit_err", bit_err_ct_o, 0);
        check("reset_inj", inj_ct_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 1'b1, 0, 1'b0);
        run_frame(1, 1'b0, 0, 1'b0);
        set_flips(3, 40, FRAME_LEN);
        run_frame(0, 1'b0, 0, 1'b0);
        set_flips(-1, -1, -1);

        // abort mid-payload
        run_frame(0, 1'b0, 20, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_ready", src_ready_o, 0);
        check("abort_enc_enable", enc_enable_o, 0);
        check("abort_enc_data", enc_data_o, 0);
        check("abort_dec_enable", dec_enable_o, 0);
        check("abort_err_mask", err_mask_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_bit_err", bit_err_ct_o, 0);
        check("abort_inj", inj_ct_o, 0);
        in_frame = 1'b0;
        exp_bits.delete();
        exp_err_q.delete(); exp_inj_q.delete(); exp_en_q.delete(); exp_run_q.delete();
        base = frames_done;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_done_after_abort", frames_done, base);
        run_frame(0, 1'b0, 0, 1'b0);

        // start pulses during TAIL and DRAIN must be ignored
        set_flips($urandom_range(0, SYMS - 1), $urandom_range(0, SYMS - 1), -1);
        base = frames_done;
        run_frame(2, 1'b0, 0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("single_done_with_pokes", frames_done, base + 1);
        check("idle_after_pokes", busy_o, 0);

        for (int k = 0; k < 3; k++) begin
            set_flips($urandom_range(0, SYMS - 1), $urandom_range(0, SYMS - 1),
                      $urandom_range(0, SYMS - 1));
            run_frame($urandom_range(0, 2), 1'b0, 0, 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame sequencer and channel scheduler for the convolutional-encoder / channel / Viterbi-decoder chain.
- Accepts payload bits from a source over valid/ready, drives the encoder enable and data, appends zero tail bits, and generates the channel error-injection mask and decoder enable.
- Checks decoder output against a latency-matched copy of the payload and reports bit-error and injection counts per frame.

Parameters:
- FRAME_LEN, 64: payload bits per frame (1..4095).
- TAIL_LEN, 2: zero flush bits after the payload (K-1).
- DEC_LAT, 16: cycles from enc_enable_o high to the matching decoded bit on dec_data_i (1..255).
- ERR_N, 4: error burst period exponent (bursts every 2**ERR_N encoder outputs).
- ERR_WINDOW, 256: number of encoder outputs per frame eligible for injection.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a frame; accepted only in IDLE.
- src_valid_i  in  1  payload bit valid.
- src_data_i  in  1  payload bit.
- src_ready_o  out  1  controller accepts a payload bit.
- enc_enable_o  out  1  encoder enable (registered).
- enc_data_o  out  1  encoder input bit (registered).
- enc_valid_i  in  1  encoder output-valid strobe.
- dec_enable_o  out  1  decoder enable; enc_valid_i delayed 1 cycle.
- err_mask_o  out  2  XOR mask applied to the encoder symbol by the channel register; aligned with dec_enable_o.
- dec_data_i  in  1  decoded bit.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at end of frame.
- bit_err_ct_o  out  16  decoded payload mismatches, current/last frame.
- inj_ct_o  out  16  cycles with nonzero err_mask_o, current/last frame.

Behaviour:
- Reset (async, rst=0): state IDLE; every output 0; all counters, the reference pipe, and the injection word counter cleared.
- FSM states:
  - IDLE: src_ready_o=0. On start_i: clear bit_err_ct_o, inj_ct_o, payload counter, and word counter; go to PAYLOAD.
  - PAYLOAD: src_ready_o=1. On a handshake (src_valid_i & src_ready_o) at cycle t: enc_enable_o=1 and enc_data_o=src_data_i at t+1, and the payload counter increments. Without a handshake, enc_enable_o=0 at t+1. When the FRAME_LEN-th bit is accepted, src_ready_o drops the next cycle; go to TAIL.
  - TAIL: enc_enable_o=1, enc_data_o=0 for exactly TAIL_LEN consecutive cycles; src_ready_o=0; then go to DRAIN.
  - DRAIN: enc_enable_o=0; wait until the reference pipe holds no valid entry (at most DEC_LAT cycles); go to DONE.
  - DONE: done_o=1 for one cycle; counters hold; go to IDLE.
- start_i outside IDLE is ignored. src_valid_i outside PAYLOAD is ignored; no bit is consumed.
- Reference pipe:
  - DEC_LAT-deep shift register of {valid, payload_flag, bit}, shifted every cycle.
  - Input entry is {enc_enable_o, state_was_PAYLOAD, enc_data_o}.
  - When the output entry has valid=1 and payload_flag=1, compare it with dec_data_i; on mismatch, bit_err_ct_o increments.
  - Tail entries are never compared.
- Error scheduler:
  - Word counter wc (16 bit) increments on each enc_valid_i.
  - Mask for that symbol is 2'b10 when wc<ERR_WINDOW and wc[ERR_N-1:0] is all-ones or all-ones-minus-1; otherwise 2'b00.
  - The mask is registered with dec_enable_o, so it is nonzero only while dec_enable_o=1.
  - inj_ct_o increments on each cycle with a nonzero mask.
- Both counters saturate at 16'hFFFF. No wrap.
- Reset mid-frame: immediate return to IDLE, pipe flushed, no done_o pulse.
- bit_err_ct_o and inj_ct_o stay valid after DONE until the next accepted start_i.

Optional Feature:
- Macro: VITERBI_ERR_INJ_EN.
- Defined: the error scheduler operates as described.
- Undefined: err_mask_o is tied to 2'b00, inj_ct_o stays 0, and wc logic is removed. All other behaviour is unchanged.

Test Plan:
- Injection off, FRAME_LEN=64, TAIL_LEN=2, source always valid, ideal decoder model with DEC_LAT=16, payload 0xA5 repeated -> enc_enable_o high for 66 consecutive cycles; done_o exactly 1 pulse; bit_err_ct_o=0; inj_ct_o=0.
- Injection on, ERR_N=4, encoder valid on all 66 outputs -> err_mask_o=2'b10 for wc=14,15,30,31,46,47,62,63; inj_ct_o=8.
- Source toggling src_valid_i every other cycle -> exactly 64 payload bits consumed; enc_enable_o gaps match the valid gaps; tail still 2 contiguous cycles.
- Decoder model flips decoded payload bits 3 and 40 plus one tail bit -> bit_err_ct_o=2.
- rst pulled low during PAYLOAD after 20 bits -> all outputs 0 within the same cycle, no done_o; a new start_i then runs a full clean frame with bit_err_ct_o=0.
- start_i pulsed during TAIL and during DRAIN -> ignored; exactly one done_o pulse and no second frame.
